// File: rtl/div_bit2pwl.sv
// div_bit2pwl
//   Two independent functions clocked by cki:
//   1. A divide-by-NDIV counter whose decoded phase is registered onto cko.
//      cko is low for NDIV/2 cycles and high for the rest, so for odd NDIV
//      the high phase is the longer one.
//   2. A bit-to-level converter. On each edge it samples in, selects
//      VH or VL as the target, and moves out toward that target. Each
//      rising step is at most RISE_STEP and each falling step is at most
//      FALL_STEP. The last step lands exactly on the target.
//
// Parameters
//   NDIV   : clock division ratio, 2..65535
//   W      : width of the signed level code on out
//   VH/VL  : signed high/low level codes, VH > VL, both must fit in W bits
//   TR_CYC : rise time in cki cycles (>= 1)
//   TF_CYC : fall time in cki cycles (>= 1)
//
// Ports
//   cki     : clock, rising edge active
//   rstn    : asynchronous active-low reset. Synchronising its release is
//             the integrator's job.
//   in      : data bit to convert
//   cko     : divided clock, driven straight from a flop
//   out     : slew-limited level code, registered
//   settled : combinational, high when out equals the level selected by
//             the most recently sampled in
module div_bit2pwl #(
  parameter int NDIV   = 4,
  parameter int W      = 16,
  parameter int VH     = 100,
  parameter int VL     = -100,
  parameter int TR_CYC = 1,
  parameter int TF_CYC = 1
) (
  input  logic                cki,
  input  logic                rstn,
  input  logic                in,
  output logic                cko,
  output logic signed [W-1:0] out,
  output logic                settled
);

  // ---------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------
  localparam longint MAX_CODE = (longint'(1) <<< (W - 1)) - 1;
  localparam longint MIN_CODE = -(longint'(1) <<< (W - 1));

  if (NDIV < 2 || NDIV > 65535) begin : g_bad_ndiv
    $error("div_bit2pwl: NDIV must be in 2..65535");
  end
  if (W < 2 || W > 32) begin : g_bad_w
    $error("div_bit2pwl: W must be in 2..32");
  end
  if (VH <= VL) begin : g_bad_levels
    $error("div_bit2pwl: VH must be greater than VL");
  end
  if (TR_CYC < 1) begin : g_bad_tr
    $error("div_bit2pwl: TR_CYC must be at least 1");
  end
  if (TF_CYC < 1) begin : g_bad_tf
    $error("div_bit2pwl: TF_CYC must be at least 1");
  end
  if (longint'(VH) > MAX_CODE || longint'(VH) < MIN_CODE ||
      longint'(VL) > MAX_CODE || longint'(VL) < MIN_CODE) begin : g_bad_range
    $error("div_bit2pwl: VH and VL must be representable in W bits");
  end

  // ---------------------------------------------------------------------
  // Elaboration-time constants
  // ---------------------------------------------------------------------
  // The full swing VH-VL always fits in W+1 signed bits, so the step sizes
  // and the target-minus-out difference are carried at that width.
  localparam longint SPAN      = longint'(VH) - longint'(VL);
  localparam longint RISE_L    = (SPAN + longint'(TR_CYC) - 1) / longint'(TR_CYC);
  localparam longint FALL_L    = (SPAN + longint'(TF_CYC) - 1) / longint'(TF_CYC);

  localparam logic signed [W:0]   RISE_STEP = (W+1)'(RISE_L);
  localparam logic signed [W:0]   FALL_STEP = (W+1)'(FALL_L);
  localparam logic signed [W-1:0] VH_CODE   = W'(VH);
  localparam logic signed [W-1:0] VL_CODE   = W'(VL);

  localparam int unsigned         CW        = 16;
  localparam logic [CW-1:0]       CNT_LAST  = CW'(NDIV - 1);
  localparam logic [CW-1:0]       CNT_HALF  = CW'(NDIV / 2);

  // ---------------------------------------------------------------------
  // Divider
  // ---------------------------------------------------------------------
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          cko_d;

  always_comb begin
    cnt_d = '0;
    if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Decoding from the next count value lets cko come straight off a flop
  // while still changing on the same edge that cnt does.
  always_comb begin
    cko_d = (cnt_d >= CNT_HALF);
  end

  always_ff @(posedge cki or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      cko   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      cko   <= cko_d;
    end
  end

  // ---------------------------------------------------------------------
  // Bit-to-level slew limiter
  // ---------------------------------------------------------------------
  logic                last_in_q;
  logic signed [W-1:0] out_q;
  logic signed [W-1:0] out_d;
  logic signed [W-1:0] target;
  logic signed [W:0]   diff;
  logic signed [W:0]   neg_diff;

  always_comb begin
    target = in ? VH_CODE : VL_CODE;
  end

  // The distance to the target is compared with the step size before any
  // addition is done. When the step would reach or pass the target, out
  // lands exactly on the target. Otherwise out+step stays strictly
  // between out and the target, so it fits in W bits and no wider adder
  // or saturation is needed.
  always_comb begin
    diff     = {target[W-1], target} - {out_q[W-1], out_q};
    neg_diff = -diff;
    out_d    = out_q;
    if (diff > 0) begin
      if (diff <= RISE_STEP) begin
        out_d = target;
      end else begin
        out_d = out_q + RISE_STEP[W-1:0];
      end
    end else if (diff < 0) begin
      if (neg_diff <= FALL_STEP) begin
        out_d = target;
      end else begin
        out_d = out_q - FALL_STEP[W-1:0];
      end
    end
  end

  always_ff @(posedge cki or negedge rstn) begin
    if (!rstn) begin
      out_q     <= VL_CODE;
      last_in_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      last_in_q <= in;
    end
  end

  assign out = out_q;

  // This compares against the registered sample, not the live input.
  // settled therefore describes the level that out is currently heading to.
  always_comb begin
    settled = (out_q == (last_in_q ? VH_CODE : VL_CODE));
  end

endmodule

// File: tb/tb_div_bit2pwl.sv
module tb_div_bit2pwl;

  logic cki;
  logic rstn;
  logic in0, in1, in2;
  logic cko0, cko1, cko2;
  logic signed [15:0] out0, out1, out2;
  logic settled0, settled1, settled2;

  int tests_run;
  int tests_failed;
  int highs;

  logic [7:0] exp_cko0;
  logic [9:0] exp_cko1;

  // NDIV=4, TR=TF=1
  div_bit2pwl #(.NDIV(4), .W(16), .VH(100), .VL(-100), .TR_CYC(1), .TF_CYC(1)) dut0 (
    .cki(cki), .rstn(rstn), .in(in0), .cko(cko0), .out(out0), .settled(settled0)
  );

  // NDIV=5, TR=4, TF=3
  div_bit2pwl #(.NDIV(5), .W(16), .VH(100), .VL(-100), .TR_CYC(4), .TF_CYC(3)) dut1 (
    .cki(cki), .rstn(rstn), .in(in1), .cko(cko1), .out(out1), .settled(settled1)
  );

  // NDIV=50, TR=TF=4
  div_bit2pwl #(.NDIV(50), .W(16), .VH(100), .VL(-100), .TR_CYC(4), .TF_CYC(4)) dut2 (
    .cki(cki), .rstn(rstn), .in(in2), .cko(cko2), .out(out2), .settled(settled2)
  );

  initial cki = 1'b0;
  always #5 cki = ~cki;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge cki);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    highs        = 0;
    exp_cko0     = 8'b0110_0110;   // bit 7 = edge 1 ... bit 0 = edge 8
    exp_cko1     = 10'b01110_01110; // bit 9 = edge 1 ... bit 0 = edge 10
    rstn = 1'b0;
    in0  = 1'b0;
    in1  = 1'b0;
    in2  = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_cko0", 32'(cko0), 32'sd0);
    chk("rst_out0", out0, -32'sd100);
    chk("rst_settled0", 32'(settled0), 32'sd1);
    chk("rst_cko1", 32'(cko1), 32'sd0);
    chk("rst_out1", out1, -32'sd100);
    chk("rst_out2", out2, -32'sd100);

    // Release between edges; the next edge is edge 1
    rstn = 1'b1;

    // Divider: edges 1..100
    for (int k = 1; k <= 100; k++) begin
      step();
      if (k <= 8) chk($sformatf("div4_e%0d", k), 32'(cko0), 32'(exp_cko0[8-k]));
      if (k <= 10) chk($sformatf("div5_e%0d", k), 32'(cko1), 32'(exp_cko1[10-k]));
      if (cko2) highs++;
      if (k == 24 || k == 50 || k == 74 || k == 100)
        chk($sformatf("div50_e%0d", k), 32'(cko2), 32'sd0);
      if (k == 25 || k == 49 || k == 75 || k == 99)
        chk($sformatf("div50_e%0d", k), 32'(cko2), 32'sd1);
    end
    chk("div50_high_count", highs, 32'sd50);
    chk("idle_out1", out1, -32'sd100);
    chk("idle_settled1", 32'(settled1), 32'sd1);

    // Rise: all inputs go to 1
    in0 = 1'b1; in1 = 1'b1; in2 = 1'b1;
    step();                                  // edge 101
    chk("tr1_out0", out0, 32'sd100);
    chk("tr1_settled0", 32'(settled0), 32'sd1);
    chk("rise_a_out1", out1, -32'sd50);
    chk("rise_a_settled1", 32'(settled1), 32'sd0);
    chk("rev_a_out2", out2, -32'sd50);
    step();                                  // edge 102
    chk("rise_b_out1", out1, 32'sd0);
    chk("rev_b_out2", out2, 32'sd0);
    in2 = 1'b0;                              // reverse dut2 at out=0
    step();                                  // edge 103
    chk("rise_c_out1", out1, 32'sd50);
    chk("rise_c_settled1", 32'(settled1), 32'sd0);
    chk("rev_c_out2", out2, -32'sd50);
    chk("rev_c_settled2", 32'(settled2), 32'sd0);
    step();                                  // edge 104
    chk("rise_d_out1", out1, 32'sd100);
    chk("rise_d_settled1", 32'(settled1), 32'sd1);
    chk("rev_d_out2", out2, -32'sd100);
    chk("rev_d_settled2", 32'(settled2), 32'sd1);
    step();                                  // edge 105
    chk("hold_out1", out1, 32'sd100);
    chk("rev_hold_out2", out2, -32'sd100);
    chk("rev_hold_settled2", 32'(settled2), 32'sd1);

    // Fall with clamp on dut1; TF=1 fall on dut0
    in0 = 1'b0; in1 = 1'b0;
    step();                                  // edge 106
    chk("fall_a_out1", out1, 32'sd33);
    chk("fall_a_settled1", 32'(settled1), 32'sd0);
    chk("tf1_out0", out0, -32'sd100);
    step();                                  // edge 107
    chk("fall_b_out1", out1, -32'sd34);
    step();                                  // edge 108
    chk("fall_c_out1", out1, -32'sd100);
    chk("fall_c_settled1", 32'(settled1), 32'sd1);
    step();                                  // edge 109 idle

    // Ramp dut1 up to 50, then reset asynchronously between edges
    in1 = 1'b1;
    step();                                  // edge 110
    chk("rr_a_out1", out1, -32'sd50);
    step();                                  // edge 111
    step();                                  // edge 112: cnt 2 -> cko 1
    chk("rr_c_out1", out1, 32'sd50);
    chk("rr_c_cko1", 32'(cko1), 32'sd1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_out1", out1, -32'sd100);
    chk("arst_cko1", 32'(cko1), 32'sd0);
    chk("arst_settled1", 32'(settled1), 32'sd1);
    step();
    chk("arst_hold_out1", out1, -32'sd100);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
